alu_writeback: RTL and testbench

ALU_WRITEBACK -- requirements
Module: alu_writeback

---
 rtl/alu_writeback_pkg.sv | 16 +
 rtl/alu_writeback.sv | 124 ++++++++++++
 tb/tb_alu_writeback.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/alu_writeback_pkg.sv
// Shared processor definitions for the ALU writeback stage: FSM state
// encoding and register-file write-target selectors.
package alu_writeback_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WR_LO = 2'b01,
        ST_WR_HI = 2'b10,
        ST_DONE  = 2'b11
    } wb_state_t;

    localparam logic [1:0] SEL_GPR = 2'b00;
    localparam logic [1:0] SEL_LO  = 2'b01;
    localparam logic [1:0] SEL_HI  = 2'b10;

endpackage

// File: rtl/alu_writeback.sv
// ALU writeback stage: captures a ZHI/ZLO result and retires it to the
// register file as one GPR write or a LO-then-HI pair, counting retirements.
module alu_writeback
    import alu_writeback_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              clear_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_zhi,
    input  logic [DATA_W-1:0] in_zlo,
    input  logic              in_wide,
    input  logic [3:0]        in_dest,
    output logic              wr_en,
    output logic [1:0]        wr_sel,
    output logic [3:0]        wr_addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_ack,
    output logic              done,
    output logic [CNT_W-1:0]  retired
);

    wb_state_t         state;
    wb_state_t         state_next;
    logic [DATA_W-1:0] z_hi;
    logic [DATA_W-1:0] z_lo;
    logic              z_wide;
    logic [3:0]        z_dest;
    logic              capture;

    assign capture = in_valid && (state == ST_IDLE);

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Narrow writes to R0 skip the register file entirely but still retire.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (capture) begin
                    if (!in_wide && (in_dest == 4'd0)) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_WR_LO;
                    end
                end
            end
            ST_WR_LO: begin
                if (wr_ack) begin
                    state_next = z_wide ? ST_WR_HI : ST_DONE;
                end
            end
            ST_WR_HI: begin
                if (wr_ack) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Every output is a pure decode of registered state and Z registers.
    always_comb begin
        in_ready = 1'b0;
        wr_en    = 1'b0;
        wr_sel   = SEL_GPR;
        wr_addr  = 4'd0;
        wr_data  = '0;
        done     = 1'b0;
        case (state)
            ST_IDLE: in_ready = 1'b1;
            ST_WR_LO: begin
                wr_en   = 1'b1;
                wr_data = z_lo;
                if (z_wide) begin
                    wr_sel = SEL_LO;
                end else begin
                    wr_sel  = SEL_GPR;
                    wr_addr = z_dest;
                end
            end
            ST_WR_HI: begin
                wr_en   = 1'b1;
                wr_sel  = SEL_HI;
                wr_data = z_hi;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            z_hi   <= '0;
            z_lo   <= '0;
            z_wide <= 1'b0;
            z_dest <= 4'd0;
        end else if (capture) begin
            z_hi   <= in_zhi;
            z_lo   <= in_zlo;
            z_wide <= in_wide;
            z_dest <= in_dest;
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            retired <= '0;
        end else if (state == ST_DONE) begin
            retired <= retired + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_writeback.sv
// Directed testbench for alu_writeback: narrow, wide, stall, R0, reset and
// counter-wrap cases with hand-computed expectations.
module tb_alu_writeback;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    logic              clock;
    logic              clear_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_zhi;
    logic [DATA_W-1:0] in_zlo;
    logic              in_wide;
    logic [3:0]        in_dest;
    logic              wr_en;
    logic [1:0]        wr_sel;
    logic [3:0]        wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic              done;
    logic [CNT_W-1:0]  retired;

    int compare_count  = 0;
    int mismatch_count = 0;

    alu_writeback #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clock    (clock),
        .clear_n  (clear_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_zhi   (in_zhi),
        .in_zlo   (in_zlo),
        .in_wide  (in_wide),
        .in_dest  (in_dest),
        .wr_en    (wr_en),
        .wr_sel   (wr_sel),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ack   (wr_ack),
        .done     (done),
        .retired  (retired)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic wide,
                                 input logic [3:0] dest,
                                 input logic [DATA_W-1:0] zhi,
                                 input logic [DATA_W-1:0] zlo);
        in_valid = valid;
        in_wide  = wide;
        in_dest  = dest;
        in_zhi   = zhi;
        in_zlo   = zlo;
    endtask

    task automatic checkWrite(input string tag, input logic en, input logic [1:0] sel,
                              input logic [3:0] addr, input logic [DATA_W-1:0] data);
        checkOutput({tag, ".wr_en"},   64'(wr_en),   64'(en));
        checkOutput({tag, ".wr_sel"},  64'(wr_sel),  64'(sel));
        checkOutput({tag, ".wr_addr"}, 64'(wr_addr), 64'(addr));
        checkOutput({tag, ".wr_data"}, 64'(wr_data), 64'(data));
    endtask

    initial begin
        clear_n = 1'b0;
        wr_ack  = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'd0, '0, '0);
        #12;
        checkWrite("reset", 1'b0, 2'b00, 4'd0, 32'h0);
        checkOutput("reset.done",    64'(done),    64'd0);
        checkOutput("reset.retired", 64'(retired), 64'd0);
        clear_n = 1'b1;
        tick();
        checkOutput("idle.in_ready", 64'(in_ready), 64'd1);

        // Narrow op, ack tied high
        wr_ack = 1'b1;
        applyStimulus(1'b1, 1'b0, 4'd3, 32'h0000_00AA, 32'h0000_0005);
        tick();
        applyStimulus(1'b0, 1'b0, 4'd0, '0, '0);
        checkWrite("narrow.n1", 1'b1, 2'b00, 4'd3, 32'h0000_0005);
        checkOutput("narrow.n1.in_ready", 64'(in_ready), 64'd0);
        checkOutput("narrow.n1.done",     64'(done),     64'd0);
        tick();
        checkOutput("narrow.n2.done",  64'(done),  64'd1);
        checkOutput("narrow.n2.wr_en", 64'(wr_en), 64'd0);
        tick();
        checkOutput("narrow.retired",  64'(retired),  64'd1);
        checkOutput("narrow.in_ready", 64'(in_ready), 64'd1);
        checkOutput("narrow.done_off", 64'(done),     64'd0);

        // Wide op, ack tied high
        applyStimulus(1'b1, 1'b1, 4'd7, 32'h0000_0001, 32'hFFFF_FFFE);
        tick();
        applyStimulus(1'b0, 1'b0, 4'd0, '0, '0);
        checkWrite("wide.lo", 1'b1, 2'b01, 4'd0, 32'hFFFF_FFFE);
        tick();
        checkWrite("wide.hi", 1'b1, 2'b10, 4'd0, 32'h0000_0001);
        checkOutput("wide.hi.done", 64'(done), 64'd0);
        tick();
        checkOutput("wide.n3.done", 64'(done), 64'd1);
        tick();
        checkOutput("wide.retired", 64'(retired), 64'd2);

        // Wide op stalled three cycles in WR_LO with in_valid pulses
        wr_ack = 1'b0;
        applyStimulus(1'b1, 1'b1, 4'd2, 32'hAAAA_0000, 32'h0000_5555);
        tick();
        for (int i = 0; i < 3; i++) begin
            checkWrite("stall.lo", 1'b1, 2'b01, 4'd0, 32'h0000_5555);
            checkOutput("stall.in_ready", 64'(in_ready), 64'd0);
            applyStimulus(i[0] ? 1'b0 : 1'b1, 1'b0, 4'd9, 32'h1234_5678, 32'h9ABC_DEF0);
            tick();
        end
        applyStimulus(1'b0, 1'b0, 4'd0, '0, '0);
        checkWrite("stall.lo_final", 1'b1, 2'b01, 4'd0, 32'h0000_5555);
        wr_ack = 1'b1;
        tick();
        checkWrite("stall.hi", 1'b1, 2'b10, 4'd0, 32'hAAAA_0000);
        tick();
        checkOutput("stall.done", 64'(done), 64'd1);
        tick();
        checkOutput("stall.retired", 64'(retired), 64'd3);

        // Narrow write to R0: suppressed, retires next cycle
        applyStimulus(1'b1, 1'b0, 4'd0, 32'h0, 32'h0000_0009);
        tick();
        applyStimulus(1'b0, 1'b0, 4'd0, '0, '0);
        checkOutput("r0.wr_en", 64'(wr_en), 64'd0);
        checkOutput("r0.done",  64'(done),  64'd1);
        tick();
        checkOutput("r0.retired",  64'(retired),  64'd4);
        checkOutput("r0.in_ready", 64'(in_ready), 64'd1);

        // Reset asserted during WR_HI
        applyStimulus(1'b1, 1'b1, 4'd1, 32'hDEAD_BEEF, 32'hCAFE_F00D);
        tick();
        applyStimulus(1'b0, 1'b0, 4'd0, '0, '0);
        tick();
        checkWrite("rst.hi", 1'b1, 2'b10, 4'd0, 32'hDEAD_BEEF);
        #2;
        clear_n = 1'b0;
        #1;
        checkWrite("rst.async", 1'b0, 2'b00, 4'd0, 32'h0);
        checkOutput("rst.async.done",    64'(done),    64'd0);
        checkOutput("rst.async.retired", 64'(retired), 64'd0);
        tick();
        clear_n = 1'b1;
        tick();
        checkOutput("rst.after.done",     64'(done),     64'd0);
        checkOutput("rst.after.retired",  64'(retired),  64'd0);
        checkOutput("rst.after.in_ready", 64'(in_ready), 64'd1);
        checkOutput("rst.after.wr_en",    64'(wr_en),    64'd0);

        // Counter wrap: 15 R0 ops reach all-ones, the 16th wraps to zero
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b1, 1'b0, 4'd0, '0, 32'(i));
            tick();
            applyStimulus(1'b0, 1'b0, 4'd0, '0, '0);
            tick();
        end
        checkOutput("wrap.full", 64'(retired), 64'hF);
        applyStimulus(1'b1, 1'b0, 4'd5, '0, 32'h0000_0077);
        tick();
        applyStimulus(1'b0, 1'b0, 4'd0, '0, '0);
        checkWrite("wrap.write", 1'b1, 2'b00, 4'd5, 32'h0000_0077);
        tick();
        checkOutput("wrap.done", 64'(done), 64'd1);
        tick();
        checkOutput("wrap.zero", 64'(retired), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
